// File: rtl/shared_counter_arb.sv
// Two-requester round-robin arbiter sharing one interval counter (IDLE -> RUN -> DONE).
// Optional build macro SHARED_COUNTER_ARB_ABORT_EN: dropping req during RUN aborts the interval.
module shared_counter_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             aborted
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             owner;
    logic             ptr;
    logic             pick;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] count_q;

`ifdef SHARED_COUNTER_ARB_ABORT_EN
    logic abort_q;
`endif

    // Only a tie is settled by the pointer; a lone requester always wins.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = ptr;
        end else begin
            pick = req[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
`ifdef SHARED_COUNTER_ARB_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
`ifdef SHARED_COUNTER_ARB_ABORT_EN
            abort_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= RUN;
                        owner   <= pick;
                        count_q <= '0;
                        len_q   <= pick ? len1 : len0;
                    end
                end
                RUN: begin
`ifdef SHARED_COUNTER_ARB_ABORT_EN
                    if (!req[owner]) begin
                        state   <= IDLE;
                        count_q <= '0;
                        abort_q <= 1'b1;
                        ptr     <= ~owner;
                    end else
`endif
                    // Stop at len_q rather than wrapping, so the maximum length completes.
                    if (count_q == len_q) begin
                        state <= DONE;
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    count_q <= '0;
                    ptr     <= ~owner;
                end
                default: begin
                    state   <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign gnt   = (state != IDLE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign done  = (state == DONE) ? gnt : 2'b00;
    assign busy  = (state != IDLE);
    assign count = count_q;

`ifdef SHARED_COUNTER_ARB_ABORT_EN
    assign aborted = abort_q;
`else
    assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_shared_counter_arb.sv
// Table-driven bench for shared_counter_arb plus directed multi-cycle sequences.
module tb_shared_counter_arb;

    typedef struct {
        logic [1:0] req;
        logic [3:0] len0;
        logic [3:0] len1;
        logic [1:0] expGnt;
        logic [1:0] expDone;
        logic [3:0] expCount;
        logic       expBusy;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] count;
    logic       busy;
    logic       aborted;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    shared_counter_arb #(.WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .len0(len0),
        .len1(len1),
        .gnt(gnt),
        .done(done),
        .count(count),
        .busy(busy),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
        req  = r;
        len0 = l0;
        len1 = l1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int limit, output logic found);
        found = 1'b0;
        for (int c = 0; c < limit; c++) begin
            stepCycle();
            if (done != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic addVec(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                          input logic [1:0] g, input logic [1:0] d, input logic [3:0] c,
                          input logic b);
        vec_t v;
        v.req = r; v.len0 = l0; v.len1 = l1;
        v.expGnt = g; v.expDone = d; v.expCount = c; v.expBusy = b;
        vecs.push_back(v);
    endtask

    initial begin
        logic found;
        int   hiCycles;
        int   doneSeen;
        int   expCount;

        reset = 1'b0;
        applyStimulus(2'b00, 4'd0, 4'd0);

        // Contention from reset: requester 0 first, one IDLE cycle, then requester 1, then 0 again.
        addVec(2'b11, 4'd2, 4'd1, 2'b01, 2'b00, 4'd0, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b01, 2'b00, 4'd1, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b01, 2'b00, 4'd2, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b01, 2'b01, 4'd2, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b00, 2'b00, 4'd0, 1'b0);
        addVec(2'b11, 4'd2, 4'd1, 2'b10, 2'b00, 4'd0, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b10, 2'b00, 4'd1, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b10, 2'b10, 4'd1, 1'b1);
        addVec(2'b11, 4'd2, 4'd1, 2'b00, 2'b00, 4'd0, 1'b0);
        addVec(2'b11, 4'd2, 4'd1, 2'b01, 2'b00, 4'd0, 1'b1);
        addVec(2'b11, 4'd9, 4'd1, 2'b01, 2'b00, 4'd1, 1'b1);
        addVec(2'b11, 4'd9, 4'd1, 2'b01, 2'b00, 4'd2, 1'b1);
        addVec(2'b11, 4'd9, 4'd1, 2'b01, 2'b01, 4'd2, 1'b1);
        addVec(2'b00, 4'd3, 4'd1, 2'b00, 2'b00, 4'd0, 1'b0);
        // Lone requester 0 with len0=3 wins although the pointer favours 1.
        addVec(2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 4'd0, 1'b1);
        addVec(2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 4'd1, 1'b1);
        addVec(2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 4'd2, 1'b1);
        addVec(2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 4'd3, 1'b1);
        addVec(2'b01, 4'd3, 4'd0, 2'b01, 2'b01, 4'd3, 1'b1);
        addVec(2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 4'd0, 1'b0);
        // Zero-length interval on requester 1.
        addVec(2'b10, 4'd3, 4'd0, 2'b10, 2'b00, 4'd0, 1'b1);
        addVec(2'b10, 4'd3, 4'd0, 2'b10, 2'b10, 4'd0, 1'b1);
        addVec(2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 4'd0, 1'b0);
        addVec(2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 4'd0, 1'b0);

        #2 reset = 1'b1;
        #1;
        checkOutput("reset gnt", gnt, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset count", count, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset aborted", aborted, 0);
        stepCycle();
        stepCycle();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].len0, vecs[i].len1);
            stepCycle();
            checkOutput($sformatf("vec%0d gnt", i), gnt, vecs[i].expGnt);
            checkOutput($sformatf("vec%0d done", i), done, vecs[i].expDone);
            checkOutput($sformatf("vec%0d count", i), count, vecs[i].expCount);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d aborted", i), aborted, 0);
        end

        // Maximum length: count climbs to 15 without wrapping, grant lasts 17 cycles.
        applyStimulus(2'b10, 4'd0, 4'd15);
        hiCycles = 0;
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            stepCycle();
            if (gnt == 2'b10) begin
                hiCycles++;
                expCount = (hiCycles - 1 > 15) ? 15 : hiCycles - 1;
                checkOutput("l15 count", count, expCount);
                if (done == 2'b10) begin
                    doneSeen++;
                    checkOutput("l15 done count", count, 15);
                    applyStimulus(2'b00, 4'd0, 4'd15);
                end
            end else if (hiCycles > 0) begin
                break;
            end
        end
        checkOutput("l15 gnt cycles", hiCycles, 17);
        checkOutput("l15 done pulses", doneSeen, 1);
        checkOutput("l15 idle count", count, 0);

        // Reset in the middle of a len0=5 interval.
        applyStimulus(2'b01, 4'd5, 4'd0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("midrst pre count", count, 2);
        reset = 1'b1;
        #1;
        checkOutput("midrst gnt", gnt, 0);
        checkOutput("midrst done", done, 0);
        checkOutput("midrst count", count, 0);
        checkOutput("midrst busy", busy, 0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("midrst regrant gnt", gnt, 2'b01);
        checkOutput("midrst regrant count", count, 0);
        waitDone(20, found);
        checkOutput("midrst done found", found, 1);
        checkOutput("midrst done count", count, 5);
        applyStimulus(2'b00, 4'd5, 4'd0);
        stepCycle();
        checkOutput("midrst idle gnt", gnt, 0);

        // Requester 0 drops req at count=1 of a len0=6 interval.
        applyStimulus(2'b01, 4'd6, 4'd0);
        stepCycle();
        stepCycle();
        checkOutput("abort pre count", count, 1);
        applyStimulus(2'b00, 4'd6, 4'd0);
        stepCycle();
`ifdef SHARED_COUNTER_ARB_ABORT_EN
        checkOutput("abort gnt", gnt, 0);
        checkOutput("abort count", count, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort pulse", aborted, 1);
        stepCycle();
        checkOutput("abort pulse end", aborted, 0);
        checkOutput("abort idle gnt", gnt, 0);
`else
        checkOutput("noabort gnt", gnt, 2'b01);
        checkOutput("noabort count", count, 2);
        checkOutput("noabort aborted", aborted, 0);
        waitDone(20, found);
        checkOutput("noabort done found", found, 1);
        checkOutput("noabort done bits", done, 2'b01);
        checkOutput("noabort done count", count, 6);
        stepCycle();
        checkOutput("noabort idle gnt", gnt, 0);
`endif

        // len0 raised from 4 to 9 mid-interval; then held req re-requests after one IDLE cycle.
        applyStimulus(2'b01, 4'd4, 4'd0);
        stepCycle();
        stepCycle();
        checkOutput("lenchg pre count", count, 1);
        applyStimulus(2'b01, 4'd9, 4'd0);
        waitDone(20, found);
        checkOutput("lenchg done found", found, 1);
        checkOutput("lenchg done count", count, 4);
        applyStimulus(2'b01, 4'd0, 4'd0);
        stepCycle();
        checkOutput("held idle gnt", gnt, 0);
        checkOutput("held idle busy", busy, 0);
        stepCycle();
        checkOutput("held regrant gnt", gnt, 2'b01);
        checkOutput("held regrant count", count, 0);
        stepCycle();
        checkOutput("held regrant done", done, 2'b01);
        applyStimulus(2'b00, 4'd0, 4'd0);
        stepCycle();
        checkOutput("held final gnt", gnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
